// File: rtl/phy_rx_lane_deskew_if.sv
// Serial receive bundle for phy_rx_lane_deskew.
// master: drives data_in; slave: drives data_out, valid_out, lane_synced, rx_active, overflow.
interface phy_rx_lane_deskew_if #(
  parameter int LANES = 2
);
  logic [LANES-1:0]   data_in;
  logic [8*LANES-1:0] data_out;
  logic               valid_out;
  logic [LANES-1:0]   lane_synced;
  logic               rx_active;
  logic               overflow;

  modport master (
    output data_in,
    input  data_out, valid_out, lane_synced, rx_active, overflow
  );

  modport slave (
    input  data_in,
    output data_out, valid_out, lane_synced, rx_active, overflow
  );
endinterface

// File: rtl/phy_rx_lane_deskew.sv
// N-lane serial RX: per-lane comma byte alignment, per-lane deskew FIFO, aligned word out.
// Ports: clk_32f (bit clock), reset (async, active low), rx (slave side of the lane bundle).
module phy_rx_lane_deskew #(
  parameter int         LANES      = 2,
  parameter int         SYNC_COUNT = 4,
  parameter logic [7:0] COMMA      = 8'hBC,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic                  clk_32f,
  input  logic                  reset,
  phy_rx_lane_deskew_if.slave   rx
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] SEARCH = 2'd0;
  localparam logic [1:0] COUNT  = 2'd1;
  localparam logic [1:0] SYNCED = 2'd2;

  localparam logic [AW:0] FULL_LVL  = FIFO_DEPTH[AW:0];
  localparam logic [3:0]  SYNC_LAST = SYNC_COUNT[3:0];

  logic [LANES-1:0]   nonempty;
  logic [LANES-1:0]   drop;
  logic [LANES-1:0]   synced;
  logic [8*LANES-1:0] word;
  logic               pop;

  logic [8*LANES-1:0] dout_q;
  logic               valid_q;
  logic               active_q;
  logic               ovf_q;

  // All lanes pop together so the output word stays lane-aligned.
  assign pop = active_q & (&nonempty);

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [7:0]  sh;
    logic [7:0]  nxt;
    logic [1:0]  st;
    logic [2:0]  bc;
    logic [3:0]  cc;
    logic        sync_q;
    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW:0] wp;
    logic [AW:0] rp;
    logic [AW:0] lvl;
    logic        is_comma;
    logic        byte_done;
    logic        push;
    logic        full;
    logic        wr;

    assign nxt       = {sh[6:0], rx.data_in[k]};
    assign is_comma  = (nxt == COMMA);
    assign byte_done = (bc == 3'd7);
    assign lvl       = wp - rp;
    assign full      = (lvl == FULL_LVL);
    assign push      = (st == SYNCED) & byte_done & ~is_comma;
    // A full FIFO still accepts a byte when a pop frees a slot this cycle.
    assign wr        = push & (~full | pop);

    assign nonempty[k]     = (lvl != '0);
    assign drop[k]         = push & full & ~pop;
    assign synced[k]       = sync_q;
    assign word[8*k +: 8]  = mem[rp[AW-1:0]];

    always_ff @(posedge clk_32f or negedge reset) begin
      if (!reset) begin
        sh     <= '0;
        st     <= SEARCH;
        bc     <= '0;
        cc     <= '0;
        sync_q <= 1'b0;
      end else begin
        sh <= nxt;
        bc <= bc + 3'd1;
        case (st)
          SEARCH: begin
            if (is_comma) begin
              st <= COUNT;
              cc <= 4'd1;
              bc <= 3'd0;
            end
          end
          COUNT: begin
            if (byte_done) begin
              if (is_comma) begin
                cc <= cc + 4'd1;
                if (cc + 4'd1 == SYNC_LAST) begin
                  st     <= SYNCED;
                  sync_q <= 1'b1;
                end
              end else begin
                st <= SEARCH;
                cc <= 4'd0;
              end
            end
          end
          default: ;
        endcase
      end
    end

    always_ff @(posedge clk_32f or negedge reset) begin
      if (!reset) begin
        wp <= '0;
        rp <= '0;
      end else begin
        if (wr)  wp <= wp + 1'b1;
        if (pop) rp <= rp + 1'b1;
      end
    end

    always_ff @(posedge clk_32f) begin
      if (wr) mem[wp[AW-1:0]] <= nxt;
    end
  end

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      dout_q   <= '0;
      valid_q  <= 1'b0;
      active_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      active_q <= &synced;
      ovf_q    <= ovf_q | (|drop);
      valid_q  <= pop;
      if (pop) dout_q <= word;
    end
  end

  assign rx.data_out    = dout_q;
  assign rx.valid_out   = valid_q;
  assign rx.lane_synced = synced;
  assign rx.rx_active   = active_q;
  assign rx.overflow    = ovf_q;

endmodule

// File: doc/phy_rx_lane_deskew.md
# phy_rx_lane_deskew

Multi-lane serial receive front end for the PHY layer. Each of `LANES` serial inputs is sampled on `clk_32f` and byte-aligned independently by hunting for a comma byte (`COMMA`, default 8'hBC), which must repeat `SYNC_COUNT` times. After alignment, each lane's bit-level skew is absorbed by a per-lane byte FIFO, and the block emits one lane-aligned `8*LANES`-bit word when every lane has a byte available. It generalises the fixed two-lane, fixed-comma receive path to N lanes with configurable sync threshold, deskew depth and overflow reporting.

## Interface
- `LANES`, 2, number of serial lanes (1..8)
- `SYNC_COUNT`, 4, consecutive byte-aligned commas required to declare lane sync (2..15)
- `COMMA`, 8'hBC, alignment byte; transmitted MSB first
- `FIFO_DEPTH`, 4, per-lane deskew FIFO depth in bytes (power of 2, ≥2)
- `clk_32f`  input  1  bit-rate clock; all logic on posedge
- `reset`  input  1  asynchronous, active-low reset
- `data_in`  input  LANES  serial bit per lane, sampled on posedge `clk_32f`
- `data_out`  output  8*LANES  aligned word; lane k byte in bits [8k+7:8k]
- `valid_out`  output  1  one-cycle qualifier for `data_out`
- `lane_synced`  output  LANES  per-lane sync status
- `rx_active`  output  1  AND of `lane_synced`
- `overflow`  output  1  sticky; a byte was dropped at a full lane FIFO

## Operation
- Reset (`reset`=0, asynchronous): all outputs 0, shift registers 0, FIFOs empty, all lane FSMs in SEARCH. Deasserting reset mid-stream restarts from SEARCH, and no partial state survives.
- Per-lane shift: `nxt = {sh[6:0], data_in[k]}`; `sh <= nxt` every cycle. The first bit received becomes the MSB of the byte.
- Per-lane FSM, with a 3-bit bit counter `bc` and a comma counter `cc`:
  - SEARCH: on `nxt == COMMA`, go to COUNT, set `cc`=1 and `bc`=0. `bc` counts bits since the boundary; a byte is complete when `bc` wraps 7→0.
  - COUNT: at each byte completion, if `nxt == COMMA`, increment `cc`. When the incremented `cc` equals `SYNC_COUNT`, go to SYNCED. If `nxt` is not the comma, return to SEARCH with `cc`=0. The comparison runs only at byte boundaries.
  - SYNCED: `lane_synced[k]`=1. At each byte boundary, a comma byte is discarded (idle/fill) and a non-comma byte is pushed into the lane FIFO. There is no loss-of-sync detection; the lane stays SYNCED until reset.
- Deskew and output: when `rx_active`=1 and every FIFO is non-empty, pop one byte from every lane in the same cycle, register the concatenation onto `data_out` and pulse `valid_out`. Otherwise `valid_out`=0 and `data_out` holds its last value.
- FIFO boundaries:
  - Push and pop in the same cycle are both honoured, including when the FIFO is full (occupancy is unchanged, no overflow).
  - A push to a full FIFO without a same-cycle pop drops the byte and sets `overflow` (sticky until reset).
  - Read and write pointers wrap modulo `FIFO_DEPTH`.
- Skew tolerance: lanes can differ by up to `FIFO_DEPTH*8-1` bit times. Beyond that, overflow is flagged and the words are misaligned.

## Timing
- Comma detection is combinational on `nxt`. The FSM state and `lane_synced` update at the posedge that samples the last bit of the `SYNC_COUNT`-th comma.
- A data byte whose last bit is sampled at edge N is in the FIFO after edge N. The earliest `data_out`/`valid_out` is at edge N+1, provided all other lanes already hold a byte.
- Steady state: one `valid_out` pulse per 8 cycles. `valid_out` is never high on two consecutive cycles unless FIFOs hold backlog.
- `rx_active` is registered with a 1-cycle lag from the last `lane_synced` rise.

## Test plan
- Reset: hold `reset`=0 with random `data_in` for 20 cycles; all outputs stay 0. Release reset with constant 0 input; `lane_synced`=0 and `valid_out`=0 indefinitely.
- Two lanes, lane 1 delayed 4 bits: send 4×BC then AA×4, 55×4, 66×4 on lane 0 and 66×4, DD×4, 33×4 on lane 1. Expect both lanes synced and `data_out` = 16'h66AA ×4, then 16'hDD55 ×4, then 16'h3366 ×4, with no overflow.
- Broken sync: send BC, BC, 3C, then BC×4 followed by 5A. `lane_synced` rises only after the later 4th BC, and the first word carries 5A.
- Idle commas: send 4×BC, 12, BC, 34 on all lanes (`LANES`=4). Expect exactly two words, 32'h12121212 then 32'h34343434.
- Overflow: `FIFO_DEPTH`=4, lane 1 never synced, 6 data bytes on lane 0. `overflow` rises on the 5th byte and `valid_out` stays 0.
- Mid-stream reset: assert `reset`=0 during the data phase for 1 cycle. All outputs return to 0, and re-sync requires 4 new commas.
